// File: rtl/fofb_pkg.sv
// Shared definitions for the FOFB readout sequencer:
// state encodings, CSR field offsets and config bits.
package fofb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } fofb_state_e;

    localparam int CSR_COUNT_LSB   = 0;
    localparam int CSR_COUNT_W     = 12;
    localparam int CSR_STATE_LSB   = 12;
    localparam int CSR_BUSY_BIT    = 14;
    localparam int CSR_ENABLE_BIT  = 15;
    localparam int CSR_SKIP_LSB    = 16;
    localparam int CSR_OVERRUN_LSB = 24;

    localparam int CFG_ENABLE_BIT  = 31;
    localparam int CFG_CLEAR_BIT   = 30;

    localparam int EVENT_CNT_W     = 8;

endpackage

// File: rtl/fofb_sat_counter.sv
// Saturating event counter; clear wins over increment.
module fofb_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fofb_readout_sequencer.sv
// Sweeps BPM readout addresses into the DSP once per FA cycle,
// tracking skipped and overrun cycles in the status word.
module fofb_readout_sequencer
    import fofb_pkg::*;
#(
    parameter int FOFB_INDEX_WIDTH = 9
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        FAstrobe,
    input  logic                        readoutValid,
    input  logic                        csrStrobe,
    input  logic [31:0]                 GPIO_OUT,
    input  logic                        dspReady,
    output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
    output logic                        dataValid,
    output logic                        dataFirst,
    output logic                        dataLast,
    output logic                        cycleDone,
    output logic [31:0]                 csr
);

    localparam int W  = FOFB_INDEX_WIDTH;
    localparam int CW = W + 1;

    fofb_state_e state_q, state_d;
    logic [CW-1:0] bpm_count_q, bpm_count_d;
    logic [CW-1:0] work_cnt_q, work_cnt_d;
    logic [W-1:0]  addr_q, addr_d;
    logic          enable_q, enable_d;
    logic          seen_q, seen_d;
    logic          data_valid_q, data_valid_d;
    logic          data_first_q, data_first_d;
    logic          data_last_q, data_last_d;
    logic          cycle_done_q, cycle_done_d;

    logic          issue;
    logic          is_last;
    logic          cnt_clr;
    logic          skip_inc;
    logic          overrun_inc;
    logic [EVENT_CNT_W-1:0] skip_count;
    logic [EVENT_CNT_W-1:0] overrun_count;
    logic          gpio_unused;

    assign gpio_unused = ^GPIO_OUT[29:CW];

    // A strobe in RUN aborts, so it also suppresses that cycle's issue.
    assign issue = (state_q == ST_RUN) && enable_q
                 && dspReady && !FAstrobe;
    assign is_last = ({1'b0, addr_q} == (work_cnt_q - CW'(1)));

    assign cnt_clr     = csrStrobe && GPIO_OUT[CFG_CLEAR_BIT];
    assign skip_inc    = FAstrobe && (state_q == ST_ARMED) && !seen_q;
    assign overrun_inc = FAstrobe
                       && ((state_q == ST_RUN) || (state_q == ST_FLUSH));

    always_comb begin
        state_d      = state_q;
        bpm_count_d  = bpm_count_q;
        enable_d     = enable_q;
        work_cnt_d   = work_cnt_q;
        seen_d       = seen_q;
        addr_d       = addr_q;
        data_valid_d = issue;
        data_first_d = issue && (addr_q == '0);
        data_last_d  = issue && is_last;
        cycle_done_d = 1'b0;

        if (csrStrobe) begin
            bpm_count_d = GPIO_OUT[W:0];
            enable_d    = GPIO_OUT[CFG_ENABLE_BIT];
        end

        // seen marks that this FA cycle's readout was already consumed
        if (FAstrobe) begin
            seen_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (FAstrobe && enable_q) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!FAstrobe && readoutValid && !seen_q) begin
                    seen_d = 1'b1;
                    if (bpm_count_q == '0) begin
                        cycle_done_d = 1'b1;
                    end else begin
                        work_cnt_d = bpm_count_q;
                        addr_d     = '0;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (FAstrobe) begin
                    state_d = ST_ARMED;
                    addr_d  = '1;
                end else if (issue) begin
                    if (is_last) begin
                        state_d      = ST_FLUSH;
                        addr_d       = '1;
                        cycle_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_ARMED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable_q) begin
            state_d = ST_IDLE;
            addr_d  = '1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q      <= ST_IDLE;
            bpm_count_q  <= '0;
            enable_q     <= 1'b0;
            work_cnt_q   <= '0;
            seen_q       <= 1'b0;
            addr_q       <= '1;
            data_valid_q <= 1'b0;
            data_first_q <= 1'b0;
            data_last_q  <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bpm_count_q  <= bpm_count_d;
            enable_q     <= enable_d;
            work_cnt_q   <= work_cnt_d;
            seen_q       <= seen_d;
            addr_q       <= addr_d;
            data_valid_q <= data_valid_d;
            data_first_q <= data_first_d;
            data_last_q  <= data_last_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    fofb_sat_counter #(
        .WIDTH(EVENT_CNT_W)
    ) u_skip_cnt (
        .clk  (sysClk),
        .rst  (sysReset),
        .inc  (skip_inc),
        .clr  (cnt_clr),
        .count(skip_count)
    );

    fofb_sat_counter #(
        .WIDTH(EVENT_CNT_W)
    ) u_overrun_cnt (
        .clk  (sysClk),
        .rst  (sysReset),
        .inc  (overrun_inc),
        .clr  (cnt_clr),
        .count(overrun_count)
    );

    always_comb begin
        csr = '0;
        csr[CSR_COUNT_LSB +: CSR_COUNT_W]     = CSR_COUNT_W'(bpm_count_q);
        csr[CSR_STATE_LSB +: 2]               = state_q;
        csr[CSR_BUSY_BIT]                     = (state_q == ST_RUN)
                                              || (state_q == ST_FLUSH);
        csr[CSR_ENABLE_BIT]                   = enable_q;
        csr[CSR_SKIP_LSB +: EVENT_CNT_W]      = skip_count;
        csr[CSR_OVERRUN_LSB +: EVENT_CNT_W]   = overrun_count;
    end

    assign fofbDSPreadoutAddress = addr_q;
    assign dataValid             = data_valid_q;
    assign dataFirst             = data_first_q;
    assign dataLast              = data_last_q;
    assign cycleDone             = cycle_done_q;

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// Directed bench for fofb_readout_sequencer with a 4-bit index;
// each task drives one scenario and checks hand-computed values.
module tb_fofb_readout_sequencer;

    logic        sysClk;
    logic        sysReset;
    logic        FAstrobe;
    logic        readoutValid;
    logic        csrStrobe;
    logic [31:0] GPIO_OUT;
    logic        dspReady;
    logic [3:0]  addr;
    logic        dataValid;
    logic        dataFirst;
    logic        dataLast;
    logic        cycleDone;
    logic [31:0] csr;

    int checks = 0;
    int passed = 0;

    logic [3:0]  c_addr  [0:31];
    logic        c_dv    [0:31];
    logic        c_first [0:31];
    logic        c_last  [0:31];
    logic        c_done  [0:31];
    logic [31:0] c_csr   [0:31];
    logic [7:0]  exp31   [0:6];
    logic [4:0]  exp32   [0:8];

    fofb_readout_sequencer #(
        .FOFB_INDEX_WIDTH(4)
    ) dut (
        .sysClk               (sysClk),
        .sysReset             (sysReset),
        .FAstrobe             (FAstrobe),
        .readoutValid         (readoutValid),
        .csrStrobe            (csrStrobe),
        .GPIO_OUT             (GPIO_OUT),
        .dspReady             (dspReady),
        .fofbDSPreadoutAddress(addr),
        .dataValid            (dataValid),
        .dataFirst            (dataFirst),
        .dataLast             (dataLast),
        .cycleDone            (cycleDone),
        .csr                  (csr)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic do_reset();
        sysReset     = 1'b1;
        FAstrobe     = 1'b0;
        readoutValid = 1'b0;
        csrStrobe    = 1'b0;
        GPIO_OUT     = '0;
        dspReady     = 1'b0;
        tick();
        tick();
        sysReset = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] v);
        GPIO_OUT  = v;
        csrStrobe = 1'b1;
        tick();
        csrStrobe = 1'b0;
        GPIO_OUT  = '0;
    endtask

    task automatic fa_pulse();
        FAstrobe = 1'b1;
        tick();
        FAstrobe = 1'b0;
    endtask

    task automatic record(input int k);
        c_addr[k]  = addr;
        c_dv[k]    = dataValid;
        c_first[k] = dataFirst;
        c_last[k]  = dataLast;
        c_done[k]  = cycleDone;
        c_csr[k]   = csr;
    endtask

    // New FA cycle, then readoutValid enters RUN; entry cycle is k=0.
    task automatic start_sweep();
        readoutValid = 1'b0;
        fa_pulse();
        readoutValid = 1'b1;
        tick();
    endtask

    task automatic capture(input int n, input logic [31:0] rdy);
        record(0);
        for (int k = 1; k < n; k++) begin
            dspReady = rdy[k-1];
            tick();
            record(k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (csr !== 32'h0) $display("FAIL reset_csr got %h want 0", csr);
        else passed++;
        checks++;
        if (addr !== 4'hF) $display("FAIL reset_addr got %h want f", addr);
        else passed++;
        checks++;
        if ({dataValid, dataFirst, dataLast, cycleDone} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000",
                     {dataValid, dataFirst, dataLast, cycleDone});
        else passed++;
    endtask

    task automatic test_basic_sweep();
        logic [7:0] got;
        do_reset();
        cfg(32'h8000_0005);
        checks++;
        if (csr !== 32'h0000_8005)
            $display("FAIL cfg_csr got %h want 00008005", csr);
        else passed++;
        start_sweep();
        capture(7, 32'hFFFF_FFFF);
        exp31 = '{8'h00, 8'h1C, 8'h28, 8'h38, 8'h48, 8'hFB, 8'hF0};
        for (int k = 0; k < 7; k++) begin
            got = {c_addr[k], c_dv[k], c_first[k], c_last[k], c_done[k]};
            checks++;
            if (got !== exp31[k])
                $display("FAIL sweep5_cyc%0d got %h want %h",
                         k, got, exp31[k]);
            else passed++;
        end
        checks++;
        if (c_csr[0][14:12] !== 3'b110)
            $display("FAIL run_csr_state got %b want 110", c_csr[0][14:12]);
        else passed++;
        checks++;
        if (c_csr[5][14:12] !== 3'b111)
            $display("FAIL flush_csr_state got %b want 111",
                     c_csr[5][14:12]);
        else passed++;
        checks++;
        if (c_csr[6][14:12] !== 3'b001)
            $display("FAIL armed_after_csr got %b want 001",
                     c_csr[6][14:12]);
        else passed++;
    endtask

    task automatic test_stall();
        int nvalid;
        do_reset();
        cfg(32'h8000_0004);
        start_sweep();
        capture(9, 32'hFFFF_FFE3);
        exp32 = '{5'h00, 5'h03, 5'h05, 5'h04, 5'h04,
                  5'h04, 5'h07, 5'h1F, 5'h1E};
        nvalid = 0;
        for (int k = 0; k < 9; k++) begin
            if (c_dv[k] === 1'b1) nvalid++;
            checks++;
            if ({c_addr[k], c_dv[k]} !== exp32[k])
                $display("FAIL stall_cyc%0d got %h want %h",
                         k, {c_addr[k], c_dv[k]}, exp32[k]);
            else passed++;
        end
        checks++;
        if (nvalid !== 4)
            $display("FAIL stall_nvalid got %0d want 4", nvalid);
        else passed++;
    endtask

    task automatic test_overrun();
        int nlast;
        do_reset();
        cfg(32'h8000_0008);
        start_sweep();
        capture(3, 32'hFFFF_FFFF);
        checks++;
        if (c_addr[2] !== 4'd2)
            $display("FAIL ovr_pre_addr got %0d want 2", c_addr[2]);
        else passed++;
        FAstrobe     = 1'b1;
        readoutValid = 1'b0;
        tick();
        FAstrobe = 1'b0;
        checks++;
        if ({csr[31:24], csr[13:12], addr, dataValid} !==
            {8'd1, 2'd1, 4'hF, 1'b0})
            $display("FAIL ovr_abort got ovr=%0d st=%0d a=%h dv=%b",
                     csr[31:24], csr[13:12], addr, dataValid);
        else passed++;
        nlast = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (dataLast === 1'b1 || dataValid === 1'b1) nlast++;
        end
        checks++;
        if (nlast !== 0)
            $display("FAIL ovr_no_last got %0d want 0", nlast);
        else passed++;
        readoutValid = 1'b1;
        tick();
        checks++;
        if ({addr, csr[13:12]} !== {4'd0, 2'd2})
            $display("FAIL ovr_restart got a=%0d st=%0d want 0/2",
                     addr, csr[13:12]);
        else passed++;
        tick();
        checks++;
        if ({dataValid, dataFirst} !== 2'b11)
            $display("FAIL ovr_first got %b want 11",
                     {dataValid, dataFirst});
        else passed++;
    endtask

    task automatic test_skip();
        do_reset();
        cfg(32'h8000_0003);
        for (int k = 0; k < 3; k++) begin
            fa_pulse();
            tick();
        end
        checks++;
        if (csr[23:16] !== 8'd2)
            $display("FAIL skip_two got %0d want 2", csr[23:16]);
        else passed++;
        for (int k = 0; k < 300; k++) begin
            fa_pulse();
            tick();
        end
        checks++;
        if (csr[23:16] !== 8'd255)
            $display("FAIL skip_sat got %0d want 255", csr[23:16]);
        else passed++;
        checks++;
        if (csr[31:24] !== 8'd0)
            $display("FAIL skip_no_ovr got %0d want 0", csr[31:24]);
        else passed++;
        cfg(32'hC000_0003);
        checks++;
        if (csr[23:16] !== 8'd0)
            $display("FAIL skip_clear got %0d want 0", csr[23:16]);
        else passed++;
        fa_pulse();
        checks++;
        if (csr[23:16] !== 8'd1)
            $display("FAIL skip_after_clr got %0d want 1", csr[23:16]);
        else passed++;
    endtask

    task automatic test_zero_count();
        int nvalid;
        do_reset();
        cfg(32'h8000_0000);
        fa_pulse();
        checks++;
        if ({csr[13:12], cycleDone} !== {2'd1, 1'b0})
            $display("FAIL zero_armed got st=%0d cd=%b",
                     csr[13:12], cycleDone);
        else passed++;
        readoutValid = 1'b1;
        dspReady     = 1'b1;
        tick();
        checks++;
        if ({cycleDone, dataValid, csr[13:12]} !== {1'b1, 1'b0, 2'd1})
            $display("FAIL zero_done got cd=%b dv=%b st=%0d",
                     cycleDone, dataValid, csr[13:12]);
        else passed++;
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dataValid === 1'b1 || cycleDone === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0)
            $display("FAIL zero_quiet got %0d want 0", nvalid);
        else passed++;
    endtask

    task automatic test_full_and_reset();
        int nvalid;
        do_reset();
        cfg(32'h8000_0010);
        start_sweep();
        capture(18, 32'hFFFF_FFFF);
        nvalid = 0;
        for (int k = 0; k < 18; k++) if (c_dv[k] === 1'b1) nvalid++;
        checks++;
        if (nvalid !== 16)
            $display("FAIL full_nvalid got %0d want 16", nvalid);
        else passed++;
        checks++;
        if ({c_addr[15], c_dv[15], c_last[15]} !== {4'hF, 1'b1, 1'b0})
            $display("FAIL full_issue15 got %h",
                     {c_addr[15], c_dv[15], c_last[15]});
        else passed++;
        checks++;
        if ({c_dv[16], c_last[16], c_done[16], c_first[16]} !== 4'b1110)
            $display("FAIL full_last got %b want 1110",
                     {c_dv[16], c_last[16], c_done[16], c_first[16]});
        else passed++;
        checks++;
        if ({c_first[1], c_dv[17]} !== 2'b10)
            $display("FAIL full_edges got %b want 10",
                     {c_first[1], c_dv[17]});
        else passed++;
        start_sweep();
        tick();
        tick();
        checks++;
        if ({addr, dataValid} !== {4'd2, 1'b1})
            $display("FAIL mid_pre got a=%0d dv=%b", addr, dataValid);
        else passed++;
        sysReset = 1'b1;
        tick();
        checks++;
        if ({csr, addr, dataValid} !== {32'h0, 4'hF, 1'b0})
            $display("FAIL mid_reset got csr=%h a=%h dv=%b",
                     csr, addr, dataValid);
        else passed++;
        sysReset = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) FAstrobe = 1'b1;
            else FAstrobe = 1'b0;
            tick();
            if (dataValid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid !== 0)
            $display("FAIL post_reset_dv got %0d want 0", nvalid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_stall();
        test_overrun();
        test_skip();
        test_zero_count();
        test_full_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
